norflash_ctrl_poll: RTL and testbench

Parametrised parallel NOR flash controller. It sits between the system command logic and an AMD-style (S29AL-class) asynchronous NOR device. It executes read, program, sector erase, chip erase and software reset, each as a sequence of timed bus cycles. Completion of program and erase is detected by DQ7 data polling with a DQ5 check and a timeout, replacing fixed worst-case waits, and a level-based request/acknowledge handshake carries an error flag.

---
 rtl/norflash_ctrl_poll.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_norflash_ctrl_poll.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/norflash_ctrl_poll.sv
// AMD-style parallel NOR flash controller: timed bus cycles for read, program,
// sector/chip erase and software reset, with DQ7/DQ5 completion polling,
// timeout recovery and a level request / pulse acknowledge handshake.
module norflash_ctrl_poll #(
  parameter int unsigned      ADDR_W    = 22,
  parameter int unsigned      DATA_W    = 8,
  parameter int unsigned      BUS_CYC   = 4,
  parameter int unsigned      WE_LO     = 2,
  parameter int unsigned      RD_SAMPLE = 2,
  parameter logic [ADDR_W-1:0] UNLOCK_A1 = 'hAAA,
  parameter logic [ADDR_W-1:0] UNLOCK_A2 = 'h555,
  parameter int unsigned      TO_W      = 32,
  parameter int unsigned      PROG_TO   = 500,
  parameter int unsigned      ERASE_TO  = 50_000_000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [2:0]        cmd_i,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              busy_o,
  output logic              ack_o,
  output logic              err_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [ADDR_W-1:0] flash_addr,
  inout  wire  [DATA_W-1:0] flash_dq,
  output logic              flash_ce_n,
  output logic              flash_oe_n,
  output logic              flash_we_n,
  output logic              flash_rst_n
);

  localparam int unsigned CYC_W  = (BUS_CYC > 1) ? $clog2(BUS_CYC) : 1;
  localparam int unsigned STEP_W = 3;
  localparam int unsigned WORD_W = ADDR_W + DATA_W;

  localparam logic [2:0] CMD_READ   = 3'd0;
  localparam logic [2:0] CMD_PROG   = 3'd1;
  localparam logic [2:0] CMD_SERASE = 3'd2;
  localparam logic [2:0] CMD_CERASE = 3'd3;
  localparam logic [2:0] CMD_RESET  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WSEQ, S_POLL, S_RECOVER, S_ACK
  } state_e;

  state_e              state_q, state_d;
  logic [CYC_W-1:0]    cyc_q, cyc_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                retry_q, retry_d;
  logic                fail_q, fail_d;
  logic [2:0]          cmd_q, cmd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   samp_q, samp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                busy_q, busy_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   faddr_q, faddr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                drv_q, drv_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic                frst_n_q;

  logic                in_bus, last;
  logic [DATA_W-1:0]   samp_now;
  logic                exp7;
  logic [TO_W-1:0]     limit, to_inc;
  logic [STEP_W-1:0]   last_step;
  logic [WORD_W-1:0]   word;

  // Address/data of write-sequence step `step` for command `cmd`
  function automatic logic [WORD_W-1:0] seq_word(input logic [2:0] cmd,
                                                 input logic [STEP_W-1:0] step,
                                                 input logic [ADDR_W-1:0] a,
                                                 input logic [DATA_W-1:0] wd);
    logic [ADDR_W-1:0] fa;
    logic [DATA_W-1:0] fd;
    fa = UNLOCK_A1;
    fd = DATA_W'(8'hAA);
    case (step)
      3'd0: begin fa = UNLOCK_A1; fd = DATA_W'(8'hAA); end
      3'd1: begin fa = UNLOCK_A2; fd = DATA_W'(8'h55); end
      3'd2: begin fa = UNLOCK_A1; fd = (cmd == CMD_PROG) ? DATA_W'(8'hA0) : DATA_W'(8'h80); end
      3'd3: begin
        if (cmd == CMD_PROG) begin fa = a; fd = wd; end
        else begin fa = UNLOCK_A1; fd = DATA_W'(8'hAA); end
      end
      3'd4: begin fa = UNLOCK_A2; fd = DATA_W'(8'h55); end
      default: begin
        if (cmd == CMD_SERASE) begin fa = a; fd = DATA_W'(8'h30); end
        else begin fa = UNLOCK_A1; fd = DATA_W'(8'h10); end
      end
    endcase
    if (cmd == CMD_RESET) begin
      fa = '0;
      fd = DATA_W'(8'hF0);
    end
    return {fa, fd};
  endfunction

  assign flash_dq    = drv_q ? dout_q : {DATA_W{1'bz}};
  assign busy_o      = busy_q;
  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign flash_addr  = faddr_q;
  assign flash_ce_n  = ce_n_q;
  assign flash_oe_n  = oe_n_q;
  assign flash_we_n  = we_n_q;
  assign flash_rst_n = frst_n_q;

  // State, datapath and output registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= S_IDLE;
      cyc_q    <= '0;
      step_q   <= '0;
      to_q     <= '0;
      retry_q  <= 1'b0;
      fail_q   <= 1'b0;
      cmd_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      samp_q   <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      faddr_q  <= '0;
      dout_q   <= '0;
      drv_q    <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      frst_n_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      step_q   <= step_d;
      to_q     <= to_d;
      retry_q  <= retry_d;
      fail_q   <= fail_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      samp_q   <= samp_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      faddr_q  <= faddr_d;
      dout_q   <= dout_d;
      drv_q    <= drv_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      frst_n_q <= 1'b1;
    end
  end

  // Next state: bus-cycle sequencing, polling decisions and timeout
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    step_d    = step_q;
    to_d      = to_q;
    retry_d   = retry_q;
    fail_d    = fail_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    samp_d    = samp_q;
    rdata_d   = rdata_q;
    in_bus    = (state_q == S_READ) || (state_q == S_WSEQ) ||
                (state_q == S_POLL) || (state_q == S_RECOVER);
    last      = (cyc_q == CYC_W'(BUS_CYC - 1));
    samp_now  = (cyc_q == CYC_W'(RD_SAMPLE)) ? flash_dq : samp_q;
    exp7      = (cmd_q == CMD_PROG) ? wdata_q[7] : 1'b1;
    limit     = (cmd_q == CMD_PROG) ? TO_W'(PROG_TO) : TO_W'(ERASE_TO);
    to_inc    = (&to_q) ? to_q : to_q + TO_W'(1);
    last_step = (cmd_q == CMD_PROG) ? 3'd3 : ((cmd_q == CMD_RESET) ? 3'd0 : 3'd5);

    if ((state_q == S_READ) || (state_q == S_POLL)) samp_d = samp_now;
    if (in_bus) cyc_d = last ? '0 : cyc_q + CYC_W'(1);

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          cmd_d   = cmd_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          cyc_d   = '0;
          step_d  = '0;
          retry_d = 1'b0;
          fail_d  = 1'b0;
          case (cmd_i)
            CMD_READ: state_d = S_READ;
            CMD_PROG, CMD_SERASE, CMD_CERASE, CMD_RESET: state_d = S_WSEQ;
            default: begin
              state_d = S_ACK;
              fail_d  = 1'b1;
            end
          endcase
        end
      end
      S_READ: begin
        if (last) begin
          rdata_d = samp_now;
          state_d = S_ACK;
        end
      end
      S_WSEQ: begin
        if (last) begin
          if (step_q == last_step) begin
            if (cmd_q == CMD_RESET) begin
              state_d = S_ACK;
            end else begin
              state_d = S_POLL;
              to_d    = '0;
              retry_d = 1'b0;
            end
          end else begin
            step_d = step_q + STEP_W'(1);
          end
        end
      end
      S_POLL: begin
        to_d = to_inc;
        if (last) begin
          if (samp_now[7] == exp7)  state_d = S_ACK;
          else if (retry_q)         state_d = S_RECOVER;
          else if (samp_now[5])     retry_d = 1'b1;
          else if (to_inc >= limit) state_d = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (last) begin
          state_d = S_ACK;
          fail_d  = 1'b1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: strobes, address and data for the upcoming cycle
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    ack_d   = (state_d == S_ACK);
    err_d   = (state_d == S_ACK) && fail_d;
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    drv_d   = 1'b0;
    faddr_d = faddr_q;
    dout_d  = dout_q;
    word    = seq_word(cmd_d, step_d, addr_d, wdata_d);
    case (state_d)
      S_READ, S_POLL: begin
        ce_n_d  = 1'b0;
        oe_n_d  = 1'b0;
        faddr_d = addr_d;
      end
      S_WSEQ: begin
        ce_n_d  = 1'b0;
        we_n_d  = !((cyc_d >= CYC_W'(1)) && (cyc_d <= CYC_W'(WE_LO)));
        drv_d   = 1'b1;
        faddr_d = word[WORD_W-1:DATA_W];
        dout_d  = word[DATA_W-1:0];
      end
      S_RECOVER: begin
        ce_n_d  = 1'b0;
        we_n_d  = !((cyc_d >= CYC_W'(1)) && (cyc_d <= CYC_W'(WE_LO)));
        drv_d   = 1'b1;
        faddr_d = '0;
        dout_d  = DATA_W'(8'hF0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_norflash_ctrl_poll.sv
// Bench for norflash_ctrl_poll: directed test-plan cases plus random operations
// against a behavioural flash model and an operation-level expectation model.
module tb_norflash_ctrl_poll;

  localparam int unsigned BC       = 4;
  localparam int unsigned WL       = 2;
  localparam int unsigned PROG_T   = 500;
  localparam int unsigned ERASE_T  = 200;
  localparam int unsigned WAIT_MAX = 3000;
  localparam logic [21:0] A1       = 22'hAAA;
  localparam logic [21:0] A2       = 22'h555;

  typedef struct { logic [21:0] a; logic [7:0] d; } wr_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b1;
  logic [2:0]  cmd_i = '0;
  logic        req_i = 1'b0;
  logic [21:0] addr_i = '0;
  logic [7:0]  wdata_i = '0;
  logic        busy_o, ack_o, err_o;
  logic [7:0]  rdata_o;
  logic [21:0] flash_addr;
  wire  [7:0]  flash_dq;
  logic        flash_ce_n, flash_oe_n, flash_we_n, flash_rst_n;

  int n_chk = 0;
  int n_fail = 0;

  // flash model state
  logic [7:0]  mem [int unsigned];
  logic [7:0]  scr_q[$];
  logic [7:0]  mdl_val = '0;
  logic [7:0]  busyval = '0;
  bit          mdl_busy = 1'b0;
  logic [21:0] cur_addr = '0;
  wr_t         wr_q[$];
  int          ce_cyc = 0, rd_cnt = 0, rd_bad = 0, we_bad = 0, bus_cnt = 0;

  norflash_ctrl_poll #(
    .ADDR_W(22), .DATA_W(8), .BUS_CYC(BC), .WE_LO(WL), .RD_SAMPLE(2),
    .UNLOCK_A1(22'hAAA), .UNLOCK_A2(22'h555), .TO_W(32),
    .PROG_TO(PROG_T), .ERASE_TO(ERASE_T)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cmd_i(cmd_i), .req_i(req_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .busy_o(busy_o), .ack_o(ack_o),
    .err_o(err_o), .rdata_o(rdata_o), .flash_addr(flash_addr),
    .flash_dq(flash_dq), .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n),
    .flash_we_n(flash_we_n), .flash_rst_n(flash_rst_n)
  );

  always #5 sys_clk = ~sys_clk;

  assign flash_dq = (!flash_oe_n && !flash_ce_n) ? mdl_val : 8'hzz;

  // Bus monitor and device model, sampled mid-cycle
  always @(negedge sys_clk) begin
    int idx;
    if (!flash_ce_n) begin
      idx = bus_cnt % BC;
      bus_cnt++;
      ce_cyc++;
      if (flash_oe_n) begin
        if (idx == 0) wr_q.push_back('{a: flash_addr, d: flash_dq});
        if (flash_we_n !== !(idx >= 1 && idx <= WL)) we_bad++;
      end else begin
        if (flash_we_n !== 1'b1) we_bad++;
        if (idx == 0) begin
          rd_cnt++;
          if (flash_addr !== cur_addr) rd_bad++;
          if (mdl_busy) mdl_val = (scr_q.size() > 0) ? scr_q.pop_front() : busyval;
          else mdl_val = mem.exists(32'(flash_addr)) ? mem[32'(flash_addr)] : 8'hFF;
        end
      end
    end else begin
      bus_cnt = 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Poll outcome from the status stream: number of reads and failure flag
  function automatic void ref_poll(input logic [7:0] s[$], input logic e7,
                                   input int unsigned lim, output int n, output bit fail);
    logic [7:0] b;
    bit retry = 1'b0;
    n = 0;
    fail = 1'b1;
    for (int k = 1; k <= 100000; k++) begin
      b = (k <= s.size()) ? s[k-1] : {~e7, 7'h00};
      if (b[7] == e7) begin n = k; fail = 1'b0; return; end
      if (retry) begin n = k; fail = 1'b1; return; end
      if (b[5]) retry = 1'b1;
      else if (32'(k) * BC >= lim) begin n = k; fail = 1'b1; return; end
    end
  endfunction

  // Random poll script: some busy reads, then done, or DQ5 with/without recovery
  task automatic mk_script(input logic e7);
    int b;
    int t;
    scr_q.delete();
    b = $urandom_range(0, 4);
    for (int i = 0; i < b; i++) scr_q.push_back({~e7, 1'($urandom), 1'b0, 5'($urandom)});
    t = $urandom_range(0, 3);
    if (t >= 2) scr_q.push_back({~e7, 1'($urandom), 1'b1, 5'($urandom)});
    if (t == 3) scr_q.push_back({~e7, 7'($urandom)});
    else scr_q.push_back({e7, 7'($urandom)});
  endtask

  // Issue one operation and check handshake, latency, bus traffic and result
  task automatic do_op(input logic [2:0] cmd, input logic [21:0] a, input logic [7:0] wd,
                       input bit hold);
    wr_t exp_w[$];
    int n, lat, k, steps, exp_rd_cnt;
    bit fail, got;
    logic e7;
    int unsigned lim;
    logic [7:0] exp_rd;
    e7 = (cmd == 3'd1) ? wd[7] : 1'b1;
    lim = (cmd == 3'd1) ? PROG_T : ERASE_T;
    n = 0; fail = 1'b0; steps = 0;
    exp_rd = mem.exists(32'(a)) ? mem[32'(a)] : 8'hFF;
    case (cmd)
      3'd0: lat = BC + 1;
      3'd1, 3'd2, 3'd3: begin
        ref_poll(scr_q, e7, lim, n, fail);
        exp_w.push_back('{a: A1, d: 8'hAA});
        exp_w.push_back('{a: A2, d: 8'h55});
        if (cmd == 3'd1) begin
          exp_w.push_back('{a: A1, d: 8'hA0});
          exp_w.push_back('{a: a, d: wd});
          steps = 4;
        end else begin
          exp_w.push_back('{a: A1, d: 8'h80});
          exp_w.push_back('{a: A1, d: 8'hAA});
          exp_w.push_back('{a: A2, d: 8'h55});
          if (cmd == 3'd2) exp_w.push_back('{a: a, d: 8'h30});
          else exp_w.push_back('{a: A1, d: 8'h10});
          steps = 6;
        end
        if (fail) exp_w.push_back('{a: 22'h0, d: 8'hF0});
        lat = (steps + n + int'(fail)) * BC + 1;
      end
      3'd4: begin
        exp_w.push_back('{a: 22'h0, d: 8'hF0});
        lat = BC + 1;
      end
      default: begin lat = 1; fail = 1'b1; end
    endcase
    exp_rd_cnt = (cmd == 3'd0) ? 1 : ((cmd >= 3'd1 && cmd <= 3'd3) ? n : 0);

    wr_q.delete(); ce_cyc = 0; rd_cnt = 0; rd_bad = 0; we_bad = 0;
    cur_addr = a; mdl_busy = (cmd >= 3'd1 && cmd <= 3'd3); busyval = {~e7, 7'h00};
    chk("idle_busy", 64'(busy_o), 64'(0));
    cmd_i = cmd; addr_i = a; wdata_i = wd; req_i = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    k = 1;
    if (!hold) req_i = 1'b0;
    else begin cmd_i = 3'($urandom); addr_i = 22'($urandom); wdata_i = 8'($urandom); end
    chk("busy_after_accept", 64'(busy_o), 64'(1));
    got = 1'b0;
    while (!got && k <= WAIT_MAX) begin
      if (ack_o) got = 1'b1;
      else begin @(negedge sys_clk); k++; end
    end
    req_i = 1'b0;
    chk("ack_seen", 64'(got), 64'(1));
    chk("ack_latency", 64'(k), 64'(lat));
    chk("err", 64'(err_o), 64'(fail));
    chk("busy_at_ack", 64'(busy_o), 64'(1));
    if (cmd == 3'd0) chk("rdata", 64'(rdata_o), 64'(exp_rd));
    chk("write_count", 64'(wr_q.size()), 64'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++) begin
      chk("write_addr", 64'(wr_q[i].a), 64'(exp_w[i].a));
      chk("write_data", 64'(wr_q[i].d), 64'(exp_w[i].d));
    end
    chk("we_pattern_errs", 64'(we_bad), 64'(0));
    chk("ce_low_cycles", 64'(ce_cyc), 64'(lat - 1));
    chk("read_cycles", 64'(rd_cnt), 64'(exp_rd_cnt));
    chk("read_addr_errs", 64'(rd_bad), 64'(0));
    @(negedge sys_clk);
    chk("post_ack_low", 64'({ack_o, busy_o, err_o}), 64'(0));
    chk("post_strobes", 64'({flash_ce_n, flash_oe_n, flash_we_n}), 64'(3'b111));
    if (cmd == 3'd0) chk("rdata_held", 64'(rdata_o), 64'(exp_rd));
    scr_q.delete();
    mdl_busy = 1'b0;
  endtask

  initial begin
    logic [21:0] ra;
    logic [7:0]  rw;
    int          r;
    #2 sys_rst_n = 1'b0;
    #1;
    chk("rst_outputs", 64'({busy_o, ack_o, err_o, rdata_o}), 64'(0));
    chk("rst_strobes", 64'({flash_ce_n, flash_oe_n, flash_we_n, flash_rst_n}), 64'(4'b1110));
    chk("rst_addr", 64'(flash_addr), 64'(0));
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("flash_rst_release", 64'(flash_rst_n), 64'(1));

    // read of a known location
    mem[32'h1234] = 8'h5A;
    do_op(3'd0, 22'h001234, 8'h00, 1'b0);

    // program with three poll reads
    scr_q = '{8'h80, 8'h80, 8'h00};
    do_op(3'd1, 22'h3FFFFF, 8'h00, 1'b0);

    // sector erase that never completes: timeout and recovery
    do_op(3'd2, 22'h010000, 8'h00, 1'b0);

    // DQ5 then DQ7 mismatch on the re-read: recovery
    scr_q = '{8'h00, 8'h20, 8'h00};
    do_op(3'd1, 22'h000100, 8'h80, 1'b0);

    // DQ5 then DQ7 match on the re-read: success
    scr_q = '{8'h20, 8'h80};
    do_op(3'd1, 22'h000101, 8'h80, 1'b0);

    // unsupported command
    do_op(3'd7, 22'h000200, 8'h00, 1'b0);

    // chip erase with req held and inputs changing while busy
    scr_q = '{8'h00, 8'h80};
    do_op(3'd3, 22'h000300, 8'h00, 1'b1);

    // software reset command
    do_op(3'd4, 22'h000400, 8'h00, 1'b0);

    // reset asserted during erase polling
    scr_q.delete(); mdl_busy = 1'b1; busyval = 8'h00; cur_addr = 22'h020000;
    cmd_i = 3'd2; addr_i = 22'h020000; req_i = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    req_i = 1'b0;
    repeat (35) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    #1;
    chk("midrst_strobes", 64'({flash_ce_n, flash_oe_n, flash_we_n, flash_rst_n}), 64'(4'b1110));
    chk("midrst_outputs", 64'({busy_o, ack_o, err_o}), 64'(0));
    chk("midrst_addr", 64'(flash_addr), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      chk("midrst_no_ack", 64'({ack_o, flash_rst_n}), 64'(0));
    end
    sys_rst_n = 1'b1;
    mdl_busy = 1'b0;
    @(negedge sys_clk);
    chk("midrst_release", 64'({flash_rst_n, busy_o, ack_o}), 64'(3'b100));
    do_op(3'd0, 22'h001234, 8'h00, 1'b0);

    // random operations
    for (int it = 0; it < 24; it++) begin
      r  = $urandom_range(0, 5);
      ra = 22'($urandom);
      rw = 8'($urandom);
      case (r)
        0: begin mem[32'(ra)] = 8'($urandom); do_op(3'd0, ra, rw, 1'b0); end
        1: begin mk_script(rw[7]); do_op(3'd1, ra, rw, 1'b0); end
        2: begin mk_script(1'b1); do_op(3'd2, ra, rw, 1'b0); end
        3: begin mk_script(1'b1); do_op(3'd3, ra, rw, 1'($urandom)); end
        4: do_op(3'd4, ra, rw, 1'b0);
        default: do_op(3'($urandom_range(5, 7)), ra, rw, 1'b0);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
